// File: rtl/miriscv_lsu_if.sv
// Memory-side bus of the load/store unit: one request channel plus the returned read word.
// The LSU is the master; the memory (or the bench's memory model) is the slave.
interface miriscv_lsu_if;
    logic        data_req_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o,
        output data_we_o,
        output data_be_o,
        output data_addr_o,
        output data_wdata_o,
        input  data_rdata_i
    );

    modport slave (
        input  data_req_o,
        input  data_we_o,
        input  data_be_o,
        input  data_addr_o,
        input  data_wdata_o,
        output data_rdata_i
    );
endinterface

// File: rtl/miriscv_lsu.sv
// Load/store unit: word-aligned memory accesses, sign/zero-extended loads,
// and read-modify-write for byte and halfword stores.
module miriscv_lsu #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [31:0]         lsu_addr_i,
    input  logic [31:0]         lsu_data_i,
    output logic [31:0]         lsu_data_o,
    output logic                lsu_stall_req_o,
    output logic                lsu_done_o,
    output logic                lsu_err_o,
    miriscv_lsu_if.master       data_bus
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

    localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic        r_we;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_cnt;

    logic [31:0] r_lsu_data;
    logic        r_done;
    logic        r_err;
    logic        r_req;
    logic        r_dwe;
    logic [3:0]  r_be;
    logic [31:0] r_daddr;
    logic [31:0] r_dwdata;

    logic        w_next_done;
    logic        w_next_err;
    logic        w_next_req;
    logic        w_next_dwe;
    logic [3:0]  w_next_be;
    logic [31:0] w_next_daddr;
    logic [31:0] w_next_dwdata;

    logic        w_err_in;
    logic        w_last_wait;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic [3:0]  w_wr_be;

    assign w_last_wait = (r_state == S_WAIT) && (r_cnt == LAST_CNT);

    // Illegal sizes and misalignment are decided from the live inputs at accept time
    always_comb begin
        w_err_in = 1'b0;
        if (lsu_size_i == 3'b011 || lsu_size_i == 3'b110 || lsu_size_i == 3'b111)
            w_err_in = 1'b1;
        else if (lsu_size_i[1:0] == 2'b01 && lsu_addr_i[0])
            w_err_in = 1'b1;
        else if (lsu_size_i == 3'b010 && lsu_addr_i[1:0] != 2'b00)
            w_err_in = 1'b1;
    end

    // Lane extraction and RMW merge both work on the word arriving in the last WAIT cycle
    always_comb begin
        w_byte = data_bus.data_rdata_i[7:0];
        case (r_addr[1:0])
            2'd1:    w_byte = data_bus.data_rdata_i[15:8];
            2'd2:    w_byte = data_bus.data_rdata_i[23:16];
            2'd3:    w_byte = data_bus.data_rdata_i[31:24];
            default: w_byte = data_bus.data_rdata_i[7:0];
        endcase
        w_half = r_addr[1] ? data_bus.data_rdata_i[31:16] : data_bus.data_rdata_i[15:0];
        w_sign = ~r_size[2];
        case (r_size[1:0])
            2'b00:   w_load = {{24{w_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{w_sign & w_half[15]}}, w_half};
            default: w_load = data_bus.data_rdata_i;
        endcase
        w_merged = data_bus.data_rdata_i;
        if (r_size[1:0] == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        w_wr_be = (r_size[1:0] == 2'b00) ? (4'b0001 << r_addr[1:0])
                                         : (4'b0011 << {r_addr[1], 1'b0});
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Bus and status outputs are computed for the state being entered, so they register in step with it
    always_comb begin
        w_next_state  = r_state;
        w_next_done   = 1'b0;
        w_next_err    = 1'b0;
        w_next_req    = 1'b0;
        w_next_dwe    = 1'b0;
        w_next_be     = 4'b0000;
        w_next_daddr  = 32'h0;
        w_next_dwdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (lsu_req_i) begin
                    if (w_err_in) begin
                        w_next_state = S_DONE;
                        w_next_done  = 1'b1;
                        w_next_err   = 1'b1;
                    end else if (lsu_we_i && lsu_size_i[1:0] == 2'b10) begin
                        w_next_state  = S_WR;
                        w_next_req    = 1'b1;
                        w_next_dwe    = 1'b1;
                        w_next_be     = 4'b1111;
                        w_next_daddr  = {lsu_addr_i[31:2], 2'b00};
                        w_next_dwdata = lsu_data_i;
                    end else begin
                        w_next_state = S_RD;
                        w_next_req   = 1'b1;
                        w_next_be    = 4'b1111;
                        w_next_daddr = {lsu_addr_i[31:2], 2'b00};
                    end
                end
            end
            S_RD: w_next_state = S_WAIT;
            S_WAIT: begin
                if (w_last_wait) begin
                    if (r_we) begin
                        w_next_state  = S_WR;
                        w_next_req    = 1'b1;
                        w_next_dwe    = 1'b1;
                        w_next_be     = w_wr_be;
                        w_next_daddr  = {r_addr[31:2], 2'b00};
                        w_next_dwdata = w_merged;
                    end else begin
                        w_next_state = S_DONE;
                        w_next_done  = 1'b1;
                    end
                end
            end
            S_WR: begin
                w_next_state = S_DONE;
                w_next_done  = 1'b1;
            end
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            r_we       <= 1'b0;
            r_size     <= 3'b000;
            r_addr     <= 32'h0;
            r_wdata    <= 16'h0;
            r_cnt      <= 2'd0;
            r_lsu_data <= 32'h0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_req      <= 1'b0;
            r_dwe      <= 1'b0;
            r_be       <= 4'b0000;
            r_daddr    <= 32'h0;
            r_dwdata   <= 32'h0;
        end else begin
            if (r_state == S_IDLE && lsu_req_i) begin
                r_we    <= lsu_we_i;
                r_size  <= lsu_size_i;
                r_addr  <= lsu_addr_i;
                r_wdata <= lsu_data_i[15:0];
            end
            if (r_state == S_WAIT && !w_last_wait)
                r_cnt <= r_cnt + 2'd1;
            else
                r_cnt <= 2'd0;
            if (w_last_wait && !r_we)
                r_lsu_data <= w_load;
            r_done   <= w_next_done;
            r_err    <= w_next_err;
            r_req    <= w_next_req;
            r_dwe    <= w_next_dwe;
            r_be     <= w_next_be;
            r_daddr  <= w_next_daddr;
            r_dwdata <= w_next_dwdata;
        end
    end

    assign lsu_stall_req_o       = lsu_req_i && (r_state != S_DONE);
    assign lsu_data_o            = r_lsu_data;
    assign lsu_done_o            = r_done;
    assign lsu_err_o             = r_err;
    assign data_bus.data_req_o   = r_req;
    assign data_bus.data_we_o    = r_dwe;
    assign data_bus.data_be_o    = r_be;
    assign data_bus.data_addr_o  = r_daddr;
    assign data_bus.data_wdata_o = r_dwdata;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Bench for miriscv_lsu: two instances (latency 1 and 3), each behind a byte-enabled memory model.
// Expected results are queued when an operation is issued and compared when lsu_done_o pulses.
module tb_miriscv_lsu;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] lat;
        logic [31:0] reqs;
        logic [3:0]  wbe;
        logic [31:0] wwdata;
        logic [31:0] rdAddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  size = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    int          sel = 0;

    logic        plEn = 1'b0;
    int          plSel = 0;
    logic [5:0]  plIdx = 6'd0;
    logic [31:0] plData = 32'h0;

    logic        gReqIn [2];
    logic [31:0] gData [2];
    logic        gStall [2];
    logic        gDone [2];
    logic        gErr [2];
    logic        gReq [2];
    logic        gWe [2];
    logic [3:0]  gBe [2];
    logic [31:0] gAddr [2];
    logic [31:0] gWdata [2];

    logic [31:0] obsData;
    logic        obsStall, obsDone, obsErr, obsReq, obsWe;
    logic [3:0]  obsBe;
    logic [31:0] obsAddr, obsWdata;

    int   testCount = 0;
    int   failCount = 0;
    exp_t sbQ[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        miriscv_lsu_if bus ();
        logic [31:0] mem [0:63];
        logic [31:0] pipe [0:3];

        assign gReqIn[g] = req && (sel == g);

        miriscv_lsu #(.MEM_LATENCY(LAT)) u_dut (
            .clk_i          (clk),
            .rst_n_i        (rst),
            .lsu_req_i      (gReqIn[g]),
            .lsu_we_i       (we),
            .lsu_size_i     (size),
            .lsu_addr_i     (addr),
            .lsu_data_i     (wdata),
            .lsu_data_o     (gData[g]),
            .lsu_stall_req_o(gStall[g]),
            .lsu_done_o     (gDone[g]),
            .lsu_err_o      (gErr[g]),
            .data_bus       (bus)
        );

        // Memory returns the addressed word exactly LAT cycles after sampling a read, poison otherwise
        always @(posedge clk) begin
            if (plEn && plSel == g)
                mem[plIdx] <= plData;
            if (bus.data_req_o && bus.data_we_o)
                for (int b = 0; b < 4; b++)
                    if (bus.data_be_o[b])
                        mem[bus.data_addr_o[7:2]][b*8 +: 8] <= bus.data_wdata_o[b*8 +: 8];
            pipe[0] <= (bus.data_req_o && !bus.data_we_o) ? mem[bus.data_addr_o[7:2]] : 32'hBAD0_BAD0;
            for (int i = 1; i < 4; i++)
                pipe[i] <= pipe[i-1];
        end

        assign bus.data_rdata_i = pipe[LAT-1];
        assign gReq[g]   = bus.data_req_o;
        assign gWe[g]    = bus.data_we_o;
        assign gBe[g]    = bus.data_be_o;
        assign gAddr[g]  = bus.data_addr_o;
        assign gWdata[g] = bus.data_wdata_o;
    end

    assign obsData  = (sel == 1) ? gData[1]  : gData[0];
    assign obsStall = (sel == 1) ? gStall[1] : gStall[0];
    assign obsDone  = (sel == 1) ? gDone[1]  : gDone[0];
    assign obsErr   = (sel == 1) ? gErr[1]   : gErr[0];
    assign obsReq   = (sel == 1) ? gReq[1]   : gReq[0];
    assign obsWe    = (sel == 1) ? gWe[1]    : gWe[0];
    assign obsBe    = (sel == 1) ? gBe[1]    : gBe[0];
    assign obsAddr  = (sel == 1) ? gAddr[1]  : gAddr[0];
    assign obsWdata = (sel == 1) ? gWdata[1] : gWdata[0];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic preload(input int s, input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        plEn = 1'b1; plSel = s; plIdx = idx; plData = d;
        @(negedge clk);
        plEn = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".data"},  obsData, 32'h0);
        checkOutput({tag, ".done"},  {31'h0, obsDone}, 32'h0);
        checkOutput({tag, ".err"},   {31'h0, obsErr}, 32'h0);
        checkOutput({tag, ".req"},   {31'h0, obsReq}, 32'h0);
        checkOutput({tag, ".we"},    {31'h0, obsWe}, 32'h0);
        checkOutput({tag, ".be"},    {28'h0, obsBe}, 32'h0);
        checkOutput({tag, ".addr"},  obsAddr, 32'h0);
        checkOutput({tag, ".wdata"}, obsWdata, 32'h0);
    endtask

    // Issue one operation, watch the bus cycle by cycle, then compare against the queued expectation
    task automatic applyStimulus(input string tag, input logic opWe, input logic [2:0] opSize,
                                 input logic [31:0] opAddr, input logic [31:0] opData,
                                 input logic [31:0] expData, input logic expErr, input int expLat,
                                 input int expReqs, input logic [3:0] expWbe, input logic [31:0] expWdata,
                                 input bit dropEarly);
        exp_t        e;
        exp_t        p;
        bit          hasRead;
        bit          seen = 0;
        int          lat = -1;
        int          nReq = 0;
        logic [3:0]  wBe = 4'h0;
        logic [31:0] wWd = 32'h0;
        logic [31:0] rdA = 32'h0;
        logic        stallDone = 1'b1;
        logic        errEarly = 1'b0;
        logic        gotErr = 1'b0;
        logic [31:0] gotData = 32'h0;

        hasRead  = (expReqs == 2) || (expReqs == 1 && !opWe);
        e.data   = expData;
        e.err    = expErr;
        e.lat    = 32'(expLat);
        e.reqs   = 32'(expReqs);
        e.wbe    = expWbe;
        e.wwdata = expWdata;
        e.rdAddr = hasRead ? {opAddr[31:2], 2'b00} : 32'h0;
        sbQ.push_back(e);

        @(negedge clk);
        req = 1'b1; we = opWe; size = opSize; addr = opAddr; wdata = opData;
        #1;
        checkOutput({tag, ".stall0"}, {31'h0, obsStall}, 32'h1);
        for (int cyc = 1; cyc <= 30 && !seen; cyc++) begin
            @(negedge clk);
            if (dropEarly && cyc == 1) req = 1'b0;
            if (obsReq) begin
                nReq++;
                if (obsWe) begin
                    wBe = obsBe;
                    wWd = obsWdata;
                end else begin
                    rdA = obsAddr;
                    if (obsBe !== 4'b1111) errEarly = 1'b1;
                end
            end
            if (obsDone) begin
                seen      = 1;
                lat       = cyc;
                stallDone = obsStall;
                gotErr    = obsErr;
                gotData   = obsData;
            end else if (obsErr) begin
                errEarly = 1'b1;
            end
        end
        req = 1'b0;

        p = sbQ.pop_front();
        checkOutput({tag, ".lat"},      32'(lat), p.lat);
        checkOutput({tag, ".err"},      {31'h0, gotErr}, {31'h0, p.err});
        checkOutput({tag, ".data"},     gotData, p.data);
        checkOutput({tag, ".reqs"},     32'(nReq), p.reqs);
        checkOutput({tag, ".wbe"},      {28'h0, wBe}, {28'h0, p.wbe});
        checkOutput({tag, ".wdata"},    wWd, p.wwdata);
        checkOutput({tag, ".rdaddr"},   rdA, p.rdAddr);
        checkOutput({tag, ".stallEnd"}, {31'h0, stallDone}, 32'h0);
        checkOutput({tag, ".stray"},    {31'h0, errEarly}, 32'h0);
    endtask

    initial begin
        int sawReq;
        int sawDone;

        sel = 0;
        applyReset();
        @(negedge clk);
        checkAllZero("reset0");

        preload(0, 6'd4, 32'h8765_43A1);
        //               tag        we  size    addr          data          expData       err lat reqs wbe      wdata         drop
        applyStimulus("LB_10",     0, 3'b000, 32'h10, 32'h0,        32'hFFFF_FFA1, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("LBU_10",    0, 3'b100, 32'h10, 32'h0,        32'h0000_00A1, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("LB_11",     0, 3'b000, 32'h11, 32'h0,        32'h0000_0043, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("LH_12",     0, 3'b001, 32'h12, 32'h0,        32'hFFFF_8765, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("LW_10",     0, 3'b010, 32'h10, 32'h0,        32'h8765_43A1, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("SW_20",     1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h8765_43A1, 0, 2, 1, 4'b1111, 32'hDEAD_BEEF, 0);
        applyStimulus("LW_20",     0, 3'b010, 32'h20, 32'h0,        32'hDEAD_BEEF, 0, 3, 1, 4'b0000, 32'h0,        0);
        applyStimulus("SB_22",     1, 3'b000, 32'h22, 32'hFFFF_FF55, 32'hDEAD_BEEF, 0, 4, 2, 4'b0100, 32'hDE55_BEEF, 0);
        applyStimulus("SH_20",     1, 3'b001, 32'h20, 32'h1234_CAFE, 32'hDEAD_BEEF, 0, 4, 2, 4'b0011, 32'hDE55_CAFE, 0);
        applyStimulus("LW_20drop", 0, 3'b010, 32'h20, 32'h0,        32'hDE55_CAFE, 0, 3, 1, 4'b0000, 32'h0,        1);
        applyStimulus("LW_21err",  0, 3'b010, 32'h21, 32'h0,        32'hDE55_CAFE, 1, 1, 0, 4'b0000, 32'h0,        0);
        applyStimulus("SZ011err",  0, 3'b011, 32'h20, 32'h0,        32'hDE55_CAFE, 1, 1, 0, 4'b0000, 32'h0,        0);
        applyStimulus("LH_11err",  0, 3'b001, 32'h11, 32'h0,        32'hDE55_CAFE, 1, 1, 0, 4'b0000, 32'h0,        0);
        applyStimulus("SW_22err",  1, 3'b010, 32'h22, 32'h1111_1111, 32'hDE55_CAFE, 1, 1, 0, 4'b0000, 32'h0,        0);

        sel = 1;
        preload(1, 6'd4, 32'h8765_43A1);
        applyStimulus("L3_LHU_12", 0, 3'b101, 32'h12, 32'h0,        32'h0000_8765, 0, 5, 1, 4'b0000, 32'h0,        0);
        applyStimulus("L3_SB_13",  1, 3'b000, 32'h13, 32'h0000_0011, 32'h0000_8765, 0, 6, 2, 4'b1000, 32'h1165_43A1, 0);

        // Reset lands in the WAIT phase of a halfword RMW
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 3'b001; addr = 32'h10; wdata = 32'h0000_AAAA;
        @(negedge clk);
        checkOutput("rstmid.rdReq", {31'h0, obsReq}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkAllZero("rstmid");
        sawReq = 0;
        sawDone = 0;
        repeat (8) begin
            @(negedge clk);
            if (obsReq) sawReq++;
            if (obsDone) sawDone++;
        end
        checkOutput("rstmid.noReq",  32'(sawReq), 32'h0);
        checkOutput("rstmid.noDone", 32'(sawDone), 32'h0);
        applyStimulus("L3_LW_10", 0, 3'b010, 32'h10, 32'h0, 32'h1165_43A1, 0, 5, 1, 4'b0000, 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
